// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter and address/data multiplexer for a shared AHB-to-APB bridge port.
// Optional grant-hold timeout enabled by defining ARB_TIMEOUT_EN.
module ahb_bridge_arbiter #(
  parameter  int unsigned MASTERS  = 4,
  parameter  int unsigned WIDTH    = 32,
  parameter  int unsigned MAX_HOLD = 16,
  localparam int unsigned MW       = $clog2(MASTERS)
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [MASTERS-1:0]       HBUSREQ,
  input  logic [MASTERS-1:0]       HLOCK,
  input  logic [MASTERS*32-1:0]    HADDR_M,
  input  logic [MASTERS*2-1:0]     HTRANS_M,
  input  logic [MASTERS-1:0]       HWRITE_M,
  input  logic [MASTERS*3-1:0]     HSIZE_M,
  input  logic [MASTERS*WIDTH-1:0] HWDATA_M,
  input  logic                     HREADY,
  output logic [MASTERS-1:0]       HGRANT,
  output logic [MW-1:0]            HMASTER,
  output logic                     HMASTLOCK,
  output logic [31:0]              HADDR,
  output logic [1:0]               HTRANS,
  output logic                     HWRITE,
  output logic [2:0]               HSIZE,
  output logic [WIDTH-1:0]         HWDATA
);

  typedef enum logic [1:0] {PARK, OWN, LOCKED} state_t;

  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_BUSY = 2'b01;
  localparam logic [1:0] TR_SEQ  = 2'b11;

  state_t               state_q, state_d;
  logic [MW-1:0]        master_q, master_d;
  logic [MW-1:0]        downer_q;
  logic [MASTERS-1:0]   grant_q, grant_d;
  logic                 mastlock_q, mastlock_d;

  logic [1:0]           own_trans;
  logic                 own_req, own_lock;
  logic [1:0]           htrans_eff;
  logic                 any_req, rearb_base, hold_hit;
  logic [MW-1:0]        winner, cand;
  logic                 found;

  // Address-phase mux follows the registered owner; data phase follows the delayed owner.
  always_comb begin
    HADDR     = '0;
    HWRITE    = 1'b0;
    HSIZE     = '0;
    own_trans = TR_IDLE;
    own_req   = 1'b0;
    own_lock  = 1'b0;
    HWDATA    = '0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      if (master_q == MW'(i)) begin
        HADDR     = HADDR_M[32*i +: 32];
        HWRITE    = HWRITE_M[i];
        HSIZE     = HSIZE_M[3*i +: 3];
        own_trans = HTRANS_M[2*i +: 2];
        own_req   = HBUSREQ[i];
        own_lock  = HLOCK[i];
      end
      if (downer_q == MW'(i)) begin
        HWDATA = HWDATA_M[WIDTH*i +: WIDTH];
      end
    end
  end

  assign htrans_eff = (state_q == PARK || !own_req) ? TR_IDLE : own_trans;
  assign HTRANS     = htrans_eff;

  assign any_req    = |HBUSREQ;
  assign rearb_base = (htrans_eff != TR_SEQ) && (htrans_eff != TR_BUSY) && !own_lock;

  // First requester scanning upward from the owner; the owner itself is checked last.
  always_comb begin
    found  = 1'b0;
    winner = master_q;
    cand   = '0;
    for (int unsigned k = 1; k <= MASTERS; k++) begin
      cand = MW'((32'(master_q) + k) % MASTERS);
      if (!found && HBUSREQ[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    master_d   = master_q;
    mastlock_d = mastlock_q;
    if (HREADY) begin
      case (state_q)
        PARK: begin
          if (any_req) begin
            state_d  = OWN;
            master_d = winner;
          end
        end
        OWN: begin
          if (own_lock && own_req) begin
            state_d = LOCKED;
          end else if (rearb_base || hold_hit) begin
            if (any_req) begin
              state_d  = OWN;
              master_d = winner;
            end else begin
              state_d = PARK;
            end
          end
        end
        LOCKED: begin
          if (!own_lock) begin
            state_d = OWN;
            if (rearb_base) begin
              if (any_req) master_d = winner;
              else         state_d  = PARK;
            end
          end
        end
        default: state_d = PARK;
      endcase
      mastlock_d = (state_d == LOCKED);
    end
  end

  always_comb begin
    grant_d = '0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      grant_d[i] = (master_d == MW'(i));
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= PARK;
      master_q   <= '0;
      grant_q    <= {{(MASTERS-1){1'b0}}, 1'b1};
      mastlock_q <= 1'b0;
      downer_q   <= '0;
    end else if (HREADY) begin
      state_q    <= state_d;
      master_q   <= master_d;
      grant_q    <= grant_d;
      mastlock_q <= mastlock_d;
      downer_q   <= master_q;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q;

  assign hold_hit = (state_q == OWN) && (hold_q >= 8'(MAX_HOLD));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      hold_q <= '0;
    end else if (HREADY && (master_d != master_q)) begin
      hold_q <= '0;
    end else if ((state_q != PARK) && |(HBUSREQ & ~grant_q) && (hold_q != '1)) begin
      hold_q <= hold_q + 8'd1;
    end
  end
`else
  // No timeout: bursts always run to completion.
  assign hold_hit = (MAX_HOLD == 32'd0) & 1'b0;
`endif

  assign HGRANT    = grant_q;
  assign HMASTER   = master_q;
  assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Directed, table-driven bench for ahb_bridge_arbiter (4 masters, 32-bit data).
module tb_ahb_bridge_arbiter;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [3:0]    HBUSREQ;
  logic [3:0]    HLOCK;
  logic [127:0]  HADDR_M;
  logic [7:0]    HTRANS_M;
  logic [3:0]    HWRITE_M;
  logic [11:0]   HSIZE_M;
  logic [127:0]  HWDATA_M;
  logic          HREADY;
  logic [3:0]    HGRANT;
  logic [1:0]    HMASTER;
  logic          HMASTLOCK;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;

  logic [1:0]    tr [4];

  int checks   = 0;
  int failures = 0;

  ahb_bridge_arbiter #(.MASTERS(4), .WIDTH(32), .MAX_HOLD(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HADDR_M(HADDR_M), .HTRANS_M(HTRANS_M), .HWRITE_M(HWRITE_M), .HSIZE_M(HSIZE_M),
    .HWDATA_M(HWDATA_M), .HREADY(HREADY), .HGRANT(HGRANT), .HMASTER(HMASTER),
    .HMASTLOCK(HMASTLOCK), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] addr_of(int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  function automatic logic [31:0] wd_of(int i);
    return 32'hD000_0000 | 32'(i);
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      HADDR_M[32*i +: 32]  = addr_of(i);
      HWDATA_M[32*i +: 32] = wd_of(i);
      HTRANS_M[2*i +: 2]   = tr[i];
      HWRITE_M[i]          = (i % 2) == 1;
      HSIZE_M[3*i +: 3]    = 3'(i);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_tr(input logic [1:0] t0, input logic [1:0] t1,
                        input logic [1:0] t2, input logic [1:0] t3);
    tr[0] = t0; tr[1] = t1; tr[2] = t2; tr[3] = t3;
  endtask

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [1:0] trn;
    int         mst;
    logic [3:0] gnt;
    logic       lk;
    logic [1:0] htr;
    int         wdi;
  } vec_t;

  vec_t vt [13];

  initial begin
    // round robin, stall with pending change, park, re-grant, sole requester
    vt[0]  = '{4'b1111, 1'b1, 2'b10, 1, 4'b0010, 1'b0, 2'b10, 0};
    vt[1]  = '{4'b1111, 1'b1, 2'b10, 2, 4'b0100, 1'b0, 2'b10, 1};
    vt[2]  = '{4'b1111, 1'b1, 2'b10, 3, 4'b1000, 1'b0, 2'b10, 2};
    vt[3]  = '{4'b1111, 1'b1, 2'b10, 0, 4'b0001, 1'b0, 2'b10, 3};
    vt[4]  = '{4'b1111, 1'b1, 2'b10, 1, 4'b0010, 1'b0, 2'b10, 0};
    vt[5]  = '{4'b1111, 1'b0, 2'b10, 1, 4'b0010, 1'b0, 2'b10, 0};
    vt[6]  = '{4'b1111, 1'b0, 2'b10, 1, 4'b0010, 1'b0, 2'b10, 0};
    vt[7]  = '{4'b1111, 1'b0, 2'b10, 1, 4'b0010, 1'b0, 2'b10, 0};
    vt[8]  = '{4'b1111, 1'b1, 2'b10, 2, 4'b0100, 1'b0, 2'b10, 1};
    vt[9]  = '{4'b0000, 1'b1, 2'b10, 2, 4'b0100, 1'b0, 2'b00, 2};
    vt[10] = '{4'b0001, 1'b1, 2'b10, 0, 4'b0001, 1'b0, 2'b10, 2};
    vt[11] = '{4'b0100, 1'b1, 2'b10, 2, 4'b0100, 1'b0, 2'b10, 0};
    vt[12] = '{4'b0100, 1'b1, 2'b10, 2, 4'b0100, 1'b0, 2'b10, 2};

    HRESET  = 1'b1;
    HBUSREQ = '0;
    HLOCK   = '0;
    HREADY  = 1'b1;
    set_tr(2'b10, 2'b10, 2'b10, 2'b10);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    step();

    chk("rst_hgrant",    64'(HGRANT),    64'h1);
    chk("rst_hmaster",   64'(HMASTER),   64'h0);
    chk("rst_hmastlock", 64'(HMASTLOCK), 64'h0);
    chk("rst_htrans",    64'(HTRANS),    64'h0);
    chk("rst_haddr",     64'(HADDR),     64'(addr_of(0)));
    chk("rst_hwdata",    64'(HWDATA),    64'(wd_of(0)));

    for (int v = 0; v < 13; v++) begin
      HBUSREQ = vt[v].req;
      HREADY  = vt[v].rdy;
      set_tr(vt[v].trn, vt[v].trn, vt[v].trn, vt[v].trn);
      step();
      chk($sformatf("v%0d_hmaster", v),   64'(HMASTER),   64'(vt[v].mst));
      chk($sformatf("v%0d_hgrant", v),    64'(HGRANT),    64'(vt[v].gnt));
      chk($sformatf("v%0d_hmastlock", v), 64'(HMASTLOCK), 64'(vt[v].lk));
      chk($sformatf("v%0d_htrans", v),    64'(HTRANS),    64'(vt[v].htr));
      chk($sformatf("v%0d_haddr", v),     64'(HADDR),     64'(addr_of(vt[v].mst)));
      chk($sformatf("v%0d_hsize", v),     64'(HSIZE),     64'(vt[v].mst));
      chk($sformatf("v%0d_hwdata", v),    64'(HWDATA),    64'(wd_of(vt[v].wdi)));
    end
    HREADY = 1'b1;

    // 4-beat INCR by master 2; master 3 starts requesting on beat 2
    HBUSREQ = 4'b0100;
    set_tr(2'b00, 2'b00, 2'b10, 2'b00);
    step();
    chk("burst_b1_hmaster", 64'(HMASTER), 64'h2);
    HBUSREQ = 4'b1100;
    tr[2]   = 2'b11;
    for (int b = 2; b <= 4; b++) begin
      step();
      chk($sformatf("burst_b%0d_hmaster", b), 64'(HMASTER), 64'h2);
      chk($sformatf("burst_b%0d_htrans", b),  64'(HTRANS),  64'h3);
    end
    tr[2] = 2'b00;
    step();
    chk("burst_end_hmaster", 64'(HMASTER), 64'h3);
    chk("burst_end_hgrant",  64'(HGRANT),  64'h8);

    // locked sequence by master 1 while masters 0 and 3 request
    set_tr(2'b10, 2'b10, 2'b10, 2'b10);
    HBUSREQ = 4'b1010;
    step();
    chk("lock_grant_hmaster",   64'(HMASTER),   64'h1);
    chk("lock_grant_hmastlock", 64'(HMASTLOCK), 64'h0);
    HBUSREQ = 4'b1011;
    HLOCK   = 4'b0010;
    for (int p = 1; p <= 3; p++) begin
      step();
      chk($sformatf("lock_p%0d_hmastlock", p), 64'(HMASTLOCK), 64'h1);
      chk($sformatf("lock_p%0d_hgrant", p),    64'(HGRANT),    64'h2);
    end
    HLOCK = 4'b0000;
    step();
    chk("lock_exit_hmaster",   64'(HMASTER),   64'h3);
    chk("lock_exit_hmastlock", 64'(HMASTLOCK), 64'h0);

    // reset while LOCKED with owner 2
    HBUSREQ = 4'b0100;
    HLOCK   = 4'b0100;
    step();
    chk("rl_own_hmaster", 64'(HMASTER), 64'h2);
    step();
    chk("rl_locked_hmastlock", 64'(HMASTLOCK), 64'h1);
    #2;
    HBUSREQ = 4'b0101;
    HRESET  = 1'b1;
    #1;
    chk("rl_rst_hgrant",    64'(HGRANT),    64'h1);
    chk("rl_rst_hmaster",   64'(HMASTER),   64'h0);
    chk("rl_rst_hmastlock", 64'(HMASTLOCK), 64'h0);
    chk("rl_rst_htrans",    64'(HTRANS),    64'h0);
    @(negedge HCLK);
    HRESET  = 1'b0;
    HBUSREQ = 4'b0100;
    step();
    chk("rl_after_hmaster",   64'(HMASTER),   64'h2);
    chk("rl_after_hmastlock", 64'(HMASTLOCK), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
